// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder cell reused LSB first, WIDTH+1 cycles from start to done pulse.
// No backpressure: start is taken only in IDLE; one operation per WIDTH+2 cycles.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             load, step, finish;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    bit_cnt;
  logic             carry, mode_q, a_msb, b_msb;

  logic             x, y, s, carry_nxt, last_bit;
  logic [WIDTH-1:0] sum_sr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_bit) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The single shared cell: subtract differs only in the borrow term.
  always_comb begin
    x          = a_sr[0];
    y          = b_sr[0];
    s          = x ^ y ^ carry;
    carry_nxt  = mode_q ? ((~x & y) | (~(x ^ y) & carry))
                        : ((x & y) | (carry & (x ^ y)));
    sum_sr_nxt = {s, sum_sr[WIDTH-1:1]};
    last_bit   = (bit_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      mode_q  <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_sr  <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      mode_q  <= mode;
      a_msb   <= a[WIDTH-1];
      b_msb   <= b[WIDTH-1];
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_sr  <= sum_sr_nxt;
      bit_cnt <= bit_cnt + CW'(1);
      carry   <= carry_nxt;
    end
  end

  // Visible outputs only move on the final bit, so the previous result holds during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state_nxt == ST_DONE);
      if (finish) begin
        result <= sum_sr_nxt;
        cout   <= carry_nxt;
        ovf    <= (mode_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (s != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed, random, abort, back-to-back and a WIDTH=4 sweep.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  logic       s4_start, s4_mode;
  logic [3:0] s4_a, s4_b;
  logic       s4_busy, s4_done, s4_cout, s4_ovf;
  logic [3:0] s4_result;

  int n_checks = 0;
  int n_fail   = 0;

  int         op_busy_cnt, op_done_cnt, op_done_at, op_overlap, op_res_moved;
  logic [7:0] op_res;
  logic       op_c, op_v;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .mode(s4_mode), .a(s4_a), .b(s4_b),
    .busy(s4_busy), .done(s4_done), .result(s4_result), .cout(s4_cout), .ovf(s4_ovf)
  );

  // Reference: whole-word integer arithmetic, signed range check for overflow.
  function automatic void ref_op(input int w, input bit m, input int ua, input int ub,
                                 output int r, output bit c, output bit v);
    int full, sa, sb, sr;
    full = m ? (ua - ub) : (ua + ub);
    r    = full & ((1 << w) - 1);
    c    = m ? (ua < ub) : (((full >> w) & 1) != 0);
    sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sr   = m ? (sa - sb) : (sa + sb);
    v    = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
  endfunction

  // Drives one operation on the 8-bit instance and records what was observed.
  task automatic do_op(input bit m, input logic [7:0] x, input logic [7:0] y, input bit disturb);
    logic [7:0] prev;
    @(negedge clk);
    start = 1'b1; mode = m; a = x; b = y;
    prev = result;
    op_busy_cnt = 0; op_done_cnt = 0; op_done_at = 0; op_overlap = 0; op_res_moved = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy) op_busy_cnt++;
      if (busy && done) op_overlap++;
      if (k <= 8 && result !== prev) op_res_moved++;
      if (done) begin
        op_done_cnt++;
        op_done_at = k;
        op_res = result; op_c = cout; op_v = ovf;
      end
      if (disturb && k <= 8) begin
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
        start = (k == 3);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; mode = 0; a = 0; b = 0;
    s4_start = 0; s4_mode = 0; s4_a = 0; s4_b = 0;
    #12;
    n_checks++;
    if ({busy, done, result, cout, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0", busy, done, result, cout, ovf);
    end
    n_checks++;
    if ({s4_busy, s4_done, s4_result, s4_cout, s4_ovf} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset4: got busy=%b done=%b result=%h, want all 0", s4_busy, s4_done, s4_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [7:0] va [6] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h55};
    logic [7:0] vb [6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h55};
    bit         vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] ve [6] = '{{2'b00, 8'h7F}, {2'b10, 8'h00}, {2'b01, 8'h80},
                           {2'b10, 8'hF0}, {2'b01, 8'h7F}, {2'b00, 8'h00}};
    for (int i = 0; i < 6; i++) begin
      do_op(vm[i], va[i], vb[i], 1'b0);
      n_checks++;
      if ({op_c, op_v, op_res} !== ve[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]: got cout=%b ovf=%b result=%h, want %b %b %h",
                 i, op_c, op_v, op_res, ve[i][9], ve[i][8], ve[i][7:0]);
      end
      n_checks++;
      if (op_done_cnt != 1 || op_done_at != 9) begin
        n_fail++;
        $display("FAIL done_timing[%0d]: got %0d pulses at cycle %0d, want 1 at cycle 9", i, op_done_cnt, op_done_at);
      end
      n_checks++;
      if (op_busy_cnt != 8 || op_overlap != 0) begin
        n_fail++;
        $display("FAIL busy_window[%0d]: got busy cycles=%0d overlap=%0d, want 8 and 0", i, op_busy_cnt, op_overlap);
      end
    end
  endtask

  task automatic test_random;
    int r; bit c, v;
    logic [7:0] x, y; bit m;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom); m = 1'($urandom);
      ref_op(8, m, int'(x), int'(y), r, c, v);
      do_op(m, x, y, 1'b0);
      n_checks++;
      if (op_done_cnt != 1 || op_res !== 8'(r) || op_c !== c || op_v !== v) begin
        n_fail++;
        $display("FAIL random m=%b %h,%h: got done=%0d result=%h cout=%b ovf=%b, want 1 %h %b %b",
                 m, x, y, op_done_cnt, op_res, op_c, op_v, 8'(r), c, v);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int r; bit c, v;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x, y; bit m;
      x = 8'($urandom); y = 8'($urandom); m = 1'($urandom);
      ref_op(8, m, int'(x), int'(y), r, c, v);
      do_op(m, x, y, 1'b1);
      n_checks++;
      if (op_done_cnt != 1 || op_res !== 8'(r) || op_c !== c || op_v !== v) begin
        n_fail++;
        $display("FAIL busy_ignore[%0d]: got done=%0d result=%h cout=%b ovf=%b, want 1 %h %b %b",
                 i, op_done_cnt, op_res, op_c, op_v, 8'(r), c, v);
      end
      n_checks++;
      if (op_res_moved != 0) begin
        n_fail++;
        $display("FAIL result_hold[%0d]: result changed in %0d RUN cycles, want 0", i, op_res_moved);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    int extra_done = 0;
    do_op(1'b0, 8'h35, 8'h4A, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h12; b = 8'h34;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, result, cout, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0", busy, done, result, cout, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    n_checks++;
    if (extra_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", extra_done);
    end
    do_op(1'b0, 8'h01, 8'h02, 1'b0);
    n_checks++;
    if (op_res !== 8'h03 || op_done_at != 9 || op_done_cnt != 1) begin
      n_fail++;
      $display("FAIL after_abort: got result=%h done at %0d (%0d pulses), want 03 at 9 (1)", op_res, op_done_at, op_done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int times[$];
    int er[$]; bit ec[$]; bit ev[$];
    int r; bit c, v;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
    ref_op(8, mode, int'(a), int'(b), r, c, v);
    er.push_back(r); ec.push_back(c); ev.push_back(v);
    start = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      @(negedge clk);
      if (done) begin
        times.push_back(t);
        n_checks++;
        if (er.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_result: done at cycle %0d with no operation outstanding", t);
        end else begin
          r = er.pop_front(); c = ec.pop_front(); v = ev.pop_front();
          if (result !== 8'(r) || cout !== c || ovf !== v) begin
            n_fail++;
            $display("FAIL b2b_result: got %h %b %b, want %h %b %b", result, cout, ovf, 8'(r), c, v);
          end
        end
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
        ref_op(8, mode, int'(a), int'(b), r, c, v);
        er.push_back(r); ec.push_back(c); ev.push_back(v);
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (times.size() != 4 || times[0] != 9) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses, first at %0d, want 4 first at 9", times.size(), times.size() > 0 ? times[0] : -1);
    end
    for (int i = 1; i < times.size(); i++) begin
      n_checks++;
      if (times[i] - times[i-1] != 10) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 10", i, times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_sweep_w4;
    int r; bit c, v;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          ref_op(4, 1'(m), x, y, r, c, v);
          @(negedge clk);
          s4_start = 1'b1; s4_mode = 1'(m); s4_a = 4'(x); s4_b = 4'(y);
          @(posedge clk);
          #1 s4_start = 1'b0;
          repeat (5) @(negedge clk);
          n_checks++;
          if (s4_done !== 1'b1 || s4_result !== 4'(r) || s4_cout !== c || s4_ovf !== v) begin
            n_fail++;
            $display("FAIL sweep4 m=%0d %h,%h: got done=%b result=%h cout=%b ovf=%b, want 1 %h %b %b",
                     m, x, y, s4_done, s4_result, s4_cout, s4_ovf, 4'(r), c, v);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    test_sweep_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor that reuses a single one-bit half/full-adder cell over WIDTH clock cycles, LSB first. It is the sequential stage that sits behind the combinational adder and subtractor cells in the arithmetic path. It accepts a parallel operand pair on a start pulse and returns a parallel result with carry/borrow and signed-overflow flags, trading latency for area.

## Interface
- WIDTH, 8, operand and result width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse when result/flags become valid
- result  output  WIDTH  sum or difference, mod 2^WIDTH
- cout  output  1  add: carry out of MSB; subtract: borrow out of MSB (1 when a < b unsigned)
- ovf  output  1  two's-complement overflow of the operation

## Operation
- Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; shift registers, bit counter and carry FF cleared.
- States: IDLE, RUN, DONE.
- IDLE: on a clock edge with start=1:
  - load a and b into shift registers
  - latch mode, a[WIDTH-1] and b[WIDTH-1]
  - clear carry/borrow FF and bit counter
  - go to RUN
  - start=0 keeps IDLE.
- RUN, one bit per edge, taking x = LSB of A register, y = LSB of B register, c = carry FF:
  - add: s = x^y^c; c' = (x&y)|(c&(x^y))
  - sub: s = x^y^c; c' = (~x&y)|(~(x^y)&c)
  - s is shifted into the result register from the MSB side; A and B registers shift right by one; counter increments.
  - On the edge processing bit WIDTH-1, go to DONE and update the outputs:
    - result = full shifted register
    - cout = c'
    - ovf: add, a_msb==b_msb && result[WIDTH-1]!=a_msb; sub, a_msb!=b_msb && result[WIDTH-1]!=a_msb
- DONE: done=1 for exactly this cycle; next edge unconditionally returns to IDLE.
- start is ignored in RUN and DONE; no queuing. A start held high through DONE is accepted on the first IDLE cycle.
- Changes to a, b or mode after the start edge have no effect on the operation in flight.
- result, cout and ovf hold their last values from DONE until the next completed operation or reset. They do not change during RUN; internal shifting uses a separate register.
- Reset during RUN or DONE aborts the operation: no done pulse, outputs go to reset values.

## Timing
- Start sampled at edge E0 → busy=1 from E0 through edge E0+WIDTH.
- Outputs updated and done=1 after edge E0+WIDTH; done falls and state returns to IDLE after edge E0+WIDTH+1.
- Earliest next start accepted at edge E0+WIDTH+2; throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together; busy=0 in IDLE and DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add 0x35+0x4A: start at E0 → busy for 8 edges, done single pulse after E8; result=0x7F, cout=0, ovf=0.
- Add 0xFF+0x01 → result=0x00, cout=1, ovf=0. Add 0x7F+0x01 → result=0x80, cout=0, ovf=1.
- Sub 0x10−0x20 → result=0xF0, cout=1, ovf=0. Sub 0x80−0x01 → result=0x7F, cout=0, ovf=1. Sub 0x55−0x55 → result=0x00, cout=0, ovf=0.
- Busy/input stability: pulse start again mid-RUN with a new mode/a/b and toggle a, b and mode every cycle → ignored. Only the original operation completes, with exactly one done pulse. Previous result stays stable throughout RUN.
- Reset mid-op: assert rst at bit 4 of an add → outputs 0 immediately, no done pulse. After release, a fresh add 0x01+0x02 → result=0x03 after 8 edges.
- Back-to-back: hold start=1 continuously → operations complete every 10 cycles with done pulses spaced 10 cycles apart. Exhaustive WIDTH=4 sweep of all a, b and mode values matches the reference model.
